// File: rtl/ifu_predec_buf.sv
// Pre-decode FIFO between fetch and dispatch: classifies branch/jump, extracts
// rs1/rs2 and the branch immediate, and makes a static prediction at push time.
// Optional same-cycle bypass when the buffer is empty: define IFU_PREDEC_BYPASS_EN.
module ifu_predec_buf #(
    parameter int PC_SIZE = 32,
    parameter int DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [31:0]              i_instr,
    input  logic [PC_SIZE-1:0]       i_pc,
    input  logic                     i_flush,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [31:0]              o_instr,
    output logic [PC_SIZE-1:0]       o_pc,
    output logic [4:0]               o_rs1idx,
    output logic [4:0]               o_rs2idx,
    output logic                     o_bjp,
    output logic                     o_jal,
    output logic                     o_jalr,
    output logic                     o_bxx,
    output logic [31:0]              o_bjp_imm,
    output logic                     o_prdt_taken,
    output logic [PC_SIZE-1:0]       o_prdt_pc,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    // ------------------------------------------------------------------
    // Input-side mini decode
    // ------------------------------------------------------------------
    logic [6:0]         opcode;
    logic               dec_jal;
    logic               dec_jalr;
    logic               dec_bxx;
    logic [31:0]        imm_j;
    logic [31:0]        imm_i;
    logic [31:0]        imm_b;
    logic [31:0]        dec_imm;
    logic [PC_SIZE-1:0] imm_pc;
    logic [PC_SIZE-1:0] pc_plus_imm;
    logic [PC_SIZE-1:0] pc_plus_4;
    logic               dec_taken;
    logic [PC_SIZE-1:0] dec_prdt_pc;

    assign opcode   = i_instr[6:0];
    assign dec_jal  = (opcode == 7'b1101111);
    assign dec_jalr = (opcode == 7'b1100111);
    assign dec_bxx  = (opcode == 7'b1100011);

    assign imm_j = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
    assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign imm_b = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};

    always_comb begin
        dec_imm = 32'h0;
        if (dec_jal) begin
            dec_imm = imm_j;
        end else if (dec_jalr) begin
            dec_imm = imm_i;
        end else if (dec_bxx) begin
            dec_imm = imm_b;
        end
    end

    // Immediate is truncated or sign-extended to the PC width before adding.
    generate
        if (PC_SIZE <= 32) begin : g_imm_trunc
            assign imm_pc = dec_imm[PC_SIZE-1:0];
        end else begin : g_imm_sext
            assign imm_pc = {{(PC_SIZE-32){dec_imm[31]}}, dec_imm};
        end
    endgenerate

    assign pc_plus_imm = i_pc + imm_pc;
    assign pc_plus_4   = i_pc + PC_SIZE'(4);

    // Backward conditional branches predicted taken; JALR target is the bare
    // immediate, the fetch unit adds x[rs1] itself.
    assign dec_taken = dec_jal | dec_jalr | (dec_bxx & dec_imm[31]);

    always_comb begin
        dec_prdt_pc = pc_plus_4;
        if (dec_jalr) begin
            dec_prdt_pc = imm_pc;
        end else if (dec_jal || (dec_bxx && dec_imm[31])) begin
            dec_prdt_pc = pc_plus_imm;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [31:0]        mem_instr   [DEPTH];
    logic [PC_SIZE-1:0] mem_pc      [DEPTH];
    logic               mem_jal     [DEPTH];
    logic               mem_jalr    [DEPTH];
    logic               mem_bxx     [DEPTH];
    logic [31:0]        mem_imm     [DEPTH];
    logic               mem_taken   [DEPTH];
    logic [PC_SIZE-1:0] mem_prdt_pc [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             empty;
    logic             full;
    logic             bypass;
    logic             fifo_valid;
    logic             push;
    logic             pop;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);

`ifdef IFU_PREDEC_BYPASS_EN
    assign bypass = empty && i_valid && o_ready && !i_flush;
`else
    assign bypass = 1'b0;
`endif

    // Handshake: a beat transfers on an edge where valid && ready are both high.
    // i_ready and the FIFO-side o_valid come only from registered pointers and
    // i_flush, so there is no o_ready -> i_ready path; a full buffer refuses a
    // push even when the head is popped in the same cycle.
    assign i_ready    = !full && !i_flush;
    assign fifo_valid = !empty && !i_flush;
    assign o_valid    = fifo_valid || bypass;
    assign push       = i_valid && i_ready && !bypass;
    assign pop        = fifo_valid && o_ready;
    assign o_count    = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Payload storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_idx]   <= i_instr;
            mem_pc[wr_idx]      <= i_pc;
            mem_jal[wr_idx]     <= dec_jal;
            mem_jalr[wr_idx]    <= dec_jalr;
            mem_bxx[wr_idx]     <= dec_bxx;
            mem_imm[wr_idx]     <= dec_imm;
            mem_taken[wr_idx]   <= dec_taken;
            mem_prdt_pc[wr_idx] <= dec_prdt_pc;
        end
    end

    // ------------------------------------------------------------------
    // Output select: bypassed input, FIFO head, or all-zero when idle
    // ------------------------------------------------------------------
    always_comb begin
        o_instr      = 32'h0;
        o_pc         = '0;
        o_jal        = 1'b0;
        o_jalr       = 1'b0;
        o_bxx        = 1'b0;
        o_bjp_imm    = 32'h0;
        o_prdt_taken = 1'b0;
        o_prdt_pc    = '0;
        if (bypass) begin
            o_instr      = i_instr;
            o_pc         = i_pc;
            o_jal        = dec_jal;
            o_jalr       = dec_jalr;
            o_bxx        = dec_bxx;
            o_bjp_imm    = dec_imm;
            o_prdt_taken = dec_taken;
            o_prdt_pc    = dec_prdt_pc;
        end else if (fifo_valid) begin
            o_instr      = mem_instr[rd_idx];
            o_pc         = mem_pc[rd_idx];
            o_jal        = mem_jal[rd_idx];
            o_jalr       = mem_jalr[rd_idx];
            o_bxx        = mem_bxx[rd_idx];
            o_bjp_imm    = mem_imm[rd_idx];
            o_prdt_taken = mem_taken[rd_idx];
            o_prdt_pc    = mem_prdt_pc[rd_idx];
        end
    end

    assign o_rs1idx = o_instr[19:15];
    assign o_rs2idx = o_instr[24:20];
    assign o_bjp    = o_jal | o_jalr | o_bxx;

endmodule

// File: tb/tb_ifu_predec_buf.sv
// Directed bench for ifu_predec_buf: decode/prediction vectors, full/wrap
// ordering, flush, asynchronous reset and the optional bypass path.
module tb_ifu_predec_buf;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic        i_flush;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [4:0]  o_rs1idx;
    logic [4:0]  o_rs2idx;
    logic        o_bjp;
    logic        o_jal;
    logic        o_jalr;
    logic        o_bxx;
    logic [31:0] o_bjp_imm;
    logic        o_prdt_taken;
    logic [31:0] o_prdt_pc;
    logic [1:0]  o_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    int          nxt;
    logic [31:0] cur_instr;
    logic [31:0] cur_pc;
    int          exp_size;

    ifu_predec_buf #(.PC_SIZE(32), .DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_instr     (i_instr),
        .i_pc        (i_pc),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_instr     (o_instr),
        .o_pc        (o_pc),
        .o_rs1idx    (o_rs1idx),
        .o_rs2idx    (o_rs2idx),
        .o_bjp       (o_bjp),
        .o_jal       (o_jal),
        .o_jalr      (o_jalr),
        .o_bxx       (o_bxx),
        .o_bjp_imm   (o_bjp_imm),
        .o_prdt_taken(o_prdt_taken),
        .o_prdt_pc   (o_prdt_pc),
        .o_count     (o_count)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver tasks; all leave the bench 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
        i_valid = 1'b1;
        i_instr = instr;
        i_pc    = pc;
        tick();
        i_valid = 1'b0;
        i_instr = 32'h0;
        i_pc    = 32'h0;
    endtask

    task automatic pop_one();
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_instr = 32'h0;
        i_pc    = 32'h0;
        i_flush = 1'b0;
        o_ready = 1'b0;
        #1;
        check("rst_ovalid", o_valid, 0);
        check("rst_count", o_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_iready", i_ready, 1);

        // JAL +16
        push_one(32'h0100006F, 32'h80000000);
        check("jal_valid", o_valid, 1);
        check("jal_count", o_count, 1);
        check("jal_jal", o_jal, 1);
        check("jal_bjp", o_bjp, 1);
        check("jal_imm", o_bjp_imm, 32'h10);
        check("jal_taken", o_prdt_taken, 1);
        check("jal_prdt_pc", o_prdt_pc, 32'h80000010);
        check("jal_rs2", o_rs2idx, 5'd16);
        pop_one();
        check("idle_valid", o_valid, 0);
        check("idle_instr", o_instr, 0);
        check("idle_imm", o_bjp_imm, 0);
        check("idle_prdt_pc", o_prdt_pc, 0);

        // beq -8 (backward, taken)
        push_one(32'hFE000CE3, 32'h80000100);
        check("bback_bxx", o_bxx, 1);
        check("bback_imm", o_bjp_imm, 32'hFFFFFFF8);
        check("bback_taken", o_prdt_taken, 1);
        check("bback_prdt_pc", o_prdt_pc, 32'h800000F8);
        pop_one();

        // beq +8 (forward, not taken)
        push_one(32'h00000463, 32'h80000100);
        check("bfwd_bxx", o_bxx, 1);
        check("bfwd_imm", o_bjp_imm, 32'h8);
        check("bfwd_taken", o_prdt_taken, 0);
        check("bfwd_prdt_pc", o_prdt_pc, 32'h80000104);
        pop_one();

        // jalr x0, 0(x1)
        push_one(32'h00008067, 32'h80000200);
        check("jalr_jalr", o_jalr, 1);
        check("jalr_jal", o_jal, 0);
        check("jalr_rs1", o_rs1idx, 5'd1);
        check("jalr_imm", o_bjp_imm, 0);
        check("jalr_taken", o_prdt_taken, 1);
        check("jalr_prdt_pc", o_prdt_pc, 32'h0);
        pop_one();

        // addi x1, x0, 1 : not a branch
        push_one(32'h00100093, 32'h80000300);
        check("alu_bjp", o_bjp, 0);
        check("alu_imm", o_bjp_imm, 0);
        check("alu_taken", o_prdt_taken, 0);
        check("alu_prdt_pc", o_prdt_pc, 32'h80000304);
        check("alu_pc", o_pc, 32'h80000300);
        pop_one();

        // Fill to full, then stream through the pointer wrap
        push_one(32'h00100093, 32'h80001000);
        exp_q.push_back({32'h00100093, 32'h80001000});
        push_one(32'h00200113, 32'h80001004);
        exp_q.push_back({32'h00200113, 32'h80001004});
        check("full_iready", i_ready, 0);
        check("full_count", o_count, 2);

        nxt     = 0;
        i_valid = 1'b1;
        o_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cur_instr = 32'h00000013 + (32'(nxt) << 20);
            cur_pc    = 32'h80002000 + 32'(4 * nxt);
            i_instr   = cur_instr;
            i_pc      = cur_pc;
            exp_size  = exp_q.size();
            #1;
            check("wrap_ovalid", o_valid, (exp_size > 0) ? 1 : 0);
            check("wrap_iready", i_ready, (exp_size < 2) ? 1 : 0);
            check("wrap_count", o_count, 64'(exp_size));
            if (exp_size > 0) begin
                check("wrap_head", {o_instr, o_pc}, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (exp_size < 2) begin
                exp_q.push_back({cur_instr, cur_pc});
                nxt++;
            end
            tick();
        end
        i_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (exp_q.size() > 0) begin
                check("drain_head", {o_instr, o_pc}, exp_q[0]);
                void'(exp_q.pop_front());
                tick();
            end
        end
        o_ready = 1'b0;
        check("drain_valid", o_valid, 0);
        check("drain_count", o_count, 0);
        check("wrap_pushed", 64'(nxt), 5);

        // Flush with two held, concurrent with a push attempt
        push_one(32'h0100006F, 32'h80003000);
        push_one(32'h00000463, 32'h80003004);
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_instr = 32'h00300193;
        i_pc    = 32'h80003008;
        #1;
        check("flush_ovalid_now", o_valid, 0);
        check("flush_iready_now", i_ready, 0);
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        #1;
        check("flush_count", o_count, 0);
        check("flush_ovalid", o_valid, 0);
        check("flush_instr", o_instr, 0);
        tick();
        check("flush_dropped", o_count, 0);

        // Empty buffer, consumer ready: bypass shows the entry in the same cycle
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_instr = 32'h0100006F;
        i_pc    = 32'h80004000;
        #1;
`ifdef IFU_PREDEC_BYPASS_EN
        check("byp_ovalid", o_valid, 1);
        check("byp_prdt_pc", o_prdt_pc, 32'h80004010);
        tick();
        i_valid = 1'b0;
        o_ready = 1'b0;
        #1;
        check("byp_not_stored", o_count, 0);
`else
        check("nobyp_ovalid", o_valid, 0);
        tick();
        i_valid = 1'b0;
        o_ready = 1'b0;
        #1;
        check("nobyp_ovalid_next", o_valid, 1);
        check("nobyp_prdt_pc", o_prdt_pc, 32'h80004010);
        pop_one();
`endif

        // Asynchronous reset mid-stream with two entries held
        push_one(32'hFE000CE3, 32'h80005000);
        push_one(32'h0100006F, 32'h80005004);
        check("prerst_count", o_count, 2);
        rst_n = 1'b0;
        #1;
        check("mrst_ovalid", o_valid, 0);
        check("mrst_count", o_count, 0);
        check("mrst_instr", o_instr, 0);
        check("mrst_pc", o_pc, 0);
        check("mrst_prdt_pc", o_prdt_pc, 0);
        check("mrst_taken", o_prdt_taken, 0);
        #3;
        rst_n = 1'b1;
        #1;
        check("mrst_iready", i_ready, 1);
        tick();
        check("mrst_ovalid_after", o_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_predec_buf.md
# ifu_predec_buf

Parametrised pre-decode buffer between instruction fetch and the EXU dispatch stage. Each fetched instruction is mini-decoded on entry for branch/jump class, register indices and branch immediate, and receives a static prediction. The instruction, its PC and the decode result are stored in a DEPTH-entry FIFO and presented to the consumer through a valid/ready handshake. A synchronous flush drops all buffered entries on redirect.

## Interface
- `PC_SIZE`, 32: PC and prediction-target width.
- `DEPTH`, 2: number of FIFO entries. Must be a power of two and at least 2.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: fetch presents an instruction.
- `i_ready` out 1: buffer accepts. Equals `!full && !i_flush`.
- `i_instr` in 32: fetched RV32 instruction.
- `i_pc` in PC_SIZE: PC of `i_instr`.
- `i_flush` in 1: synchronous flush request.
- `o_valid` out 1: head entry is valid.
- `o_ready` in 1: consumer accepts the head entry.
- `o_instr` out 32, `o_pc` out PC_SIZE: head instruction and its PC.
- `o_rs1idx` out 5, `o_rs2idx` out 5: `instr[19:15]` and `instr[24:20]`.
- `o_bjp` out 1: `o_jal | o_jalr | o_bxx`.
- `o_jal` out 1: opcode `1101111`.
- `o_jalr` out 1: opcode `1100111`.
- `o_bxx` out 1: opcode `1100011`.
- `o_bjp_imm` out 32: sign-extended J, I or B immediate for the matching class, else 0.
- `o_prdt_taken` out 1: static prediction.
- `o_prdt_pc` out PC_SIZE: predicted next PC.
- `o_count` out clog2(DEPTH)+1: current occupancy.

## Operation
- Decode happens at push time. The stored entry holds instr, pc, class bits, immediate, prediction and predicted PC.
- Prediction rules:
  - JAL: taken; target = pc + imm.
  - BXX: taken iff imm[31]=1 (backward); target = pc + imm if taken, else pc + 4.
  - JALR: taken; `o_prdt_pc` = imm only. The fetch unit adds x[`o_rs1idx`] to it; when rs1idx = 0 the value is already the final target.
  - All other instructions: not taken; target = pc + 4.
- Arithmetic is modulo 2^PC_SIZE. The immediate is truncated or sign-extended to PC_SIZE before the add.
- Push when `i_valid && i_ready`. Pop when `o_valid && o_ready`.
- Pointers are clog2(DEPTH)+1 bits wide.
  - Empty: pointers are equal.
  - Full: MSBs differ and the low bits are equal.
  - Wrap-around is natural binary overflow.
- Push and pop in the same cycle: count is unchanged, and both pointers advance.
- Pushing is blocked when full, even if a pop happens in the same cycle. There is no combinational path from `o_ready` to `i_ready`.
- Flush:
  - In the cycle `i_flush`=1: `o_valid`=0 and `i_ready`=0, so no push and no pop occur.
  - At the next edge: both pointers and the count are 0.
  - Flush has priority over every other event.
- When `o_valid`=0, all payload outputs are driven to 0.
- Reset (can assert at any time, including mid-operation): pointers=0, count=0, `o_valid`=0, all payload outputs 0, `i_ready`=1 once `rst_n` is high. Storage contents are not reset.

## Timing
- Without bypass, latency is 1 cycle. An entry pushed at edge T is visible on `o_valid` after edge T.
- Sustained throughput is 1 instruction per cycle with DEPTH ≥ 2.
- `i_ready` and `o_valid` depend only on registered state and `i_flush`.
- Decode and adder logic sit on the input side, before the storage registers.

## Configuration
- `IFU_PREDEC_BYPASS_EN` defined:
  - Bypass condition: FIFO empty, `i_valid`=1, `o_ready`=1, `i_flush`=0.
  - When the condition holds, the decoded input drives the outputs combinationally with `o_valid`=1, and nothing is written into the FIFO.
  - Latency becomes 0. `o_valid` then depends combinationally on `i_valid`.
- Macro undefined: no bypass path; 1-cycle latency in all cases.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with 2 entries held. Outputs immediately show `o_valid`=0, `o_count`=0 and zero payload; `i_ready`=1 after release.
- JAL: push `0x0100006F` at pc `0x80000000`. Output `o_jal`=1, `o_bjp_imm`=0x10, `o_prdt_taken`=1, `o_prdt_pc`=0x80000010.
- Branches at pc `0x80000100`:
  - Push `0xFE000CE3` (beq -8): taken, `o_prdt_pc`=0x800000F8.
  - Push `0x00000463` (beq +8): not taken, `o_prdt_pc`=0x80000104.
- JALR: push `0x00008067` at pc `0x80000200`. Output `o_jalr`=1, `o_rs1idx`=1, `o_bjp_imm`=0, `o_prdt_taken`=1.
- Full and wrap, DEPTH=2, `o_ready`=0:
  - Push 2 entries: `i_ready`=0, `o_count`=2.
  - Then hold `i_valid`=1 and `o_ready`=1 for 6 cycles. Order is preserved across the pointer wrap with no loss and no duplicates.
- Flush with 2 entries held, concurrent with `i_valid`: the next cycle shows `o_count`=0 and `o_valid`=0, and the input is dropped. With the bypass macro, an empty FIFO with `o_ready`=1 shows `o_valid` in the same cycle as `i_valid`.
